// File: rtl/stream_serializer.sv
// stream_serializer: accepts one wide word per valid/ready handshake and
// emits it as NUM_BEATS narrow beats, least-significant beat first, flagging
// the final beat of each word. Words may stream back-to-back with no bubble
// because in_ready_o looks through to out_ready_i on the last beat.
module stream_serializer #(
  parameter int DATA_W = 128,
  parameter int BEAT_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [BEAT_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o
);

  localparam int NUM_BEATS = DATA_W / BEAT_W;
  localparam int CNT_W     = (NUM_BEATS < 2) ? 1 : $clog2(NUM_BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BEATS - 1);

  if ((NUM_BEATS < 2) || ((DATA_W % BEAT_W) != 0)) begin : g_param_check
    $error("stream_serializer: DATA_W must be a multiple of BEAT_W with at least 2 beats");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   sreg_q, sreg_d;

  logic busy;
  logic on_last;
  logic load;
  logic beat_acc;

  assign busy     = (state_q == SEND);
  assign on_last  = (cnt_q == LAST_CNT);
  assign load     = in_valid_i && in_ready_o;
  assign beat_acc = busy && out_ready_i;

  // The last-beat look-through on out_ready_i lets a new word load in the
  // same cycle the final beat of the previous word is accepted.
  assign in_ready_o  = !busy || (out_ready_i && on_last);
  assign out_valid_o = busy;
  assign busy_o      = busy;
  assign out_last_o  = busy && on_last;
  assign out_data_o  = sreg_q[BEAT_W-1:0];

  // Next-state: load wins over shift; final beat without a load returns to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    if (load) begin
      sreg_d  = in_data_i;
      cnt_d   = '0;
      state_d = SEND;
    end else if (beat_acc) begin
      if (on_last) begin
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        sreg_d = sreg_q >> BEAT_W;
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset discards any held word immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
    end
  end

endmodule
